branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, meaning BTB entry count; SHALL be a power of two in 4..256, with IDX_W = log2(ENTRIES).
REQ-002 Parameter TAG_W, default 8, meaning stored tag width; SHALL satisfy IDX_W+TAG_W+2 <= 32.
REQ-003 Parameter CNT_W, default 2, meaning saturating-counter width; SHALL be 1..3.
REQ-004 Parameter MODE, default 1, meaning 0 = static not-taken and 1 = bimodal BTB.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 if_pc  in  32  IF-stage PC being fetched.
REQ-008 pred_taken  out  1  prediction for if_pc.
REQ-009 pred_target  out  32  predicted next PC for if_pc.
REQ-010 ex_valid  in  1  a branch or jump is resolved in EX this cycle.
REQ-011 ex_pc  in  32  PC of the resolving instruction.
REQ-012 ex_taken  in  1  actual direction.
REQ-013 ex_target  in  32  actual taken target.
REQ-014 ex_pred_taken  in  1  pred_taken value carried from IF through the pipeline registers.
REQ-015 ex_pred_target  in  32  pred_target value carried from IF through the pipeline registers.
REQ-016 mispredict  out  1  flush request for IF/ID and ID/EX.
REQ-017 redirect_pc  out  32  correct next PC, used when mispredict is 1.
REQ-018 stat_clr  in  1  synchronous clear of the statistics counters.
REQ-019 stat_branches  out  32  count of resolved branches.
REQ-020 stat_mispredicts  out  32  count of mispredictions.

Function
REQ-021 Index SHALL be pc[IDX_W+1:2] and tag SHALL be pc[IDX_W+TAG_W+1:IDX_W+2]; each entry SHALL hold valid, tag, target[31:0] and cnt[CNT_W-1:0].
REQ-022 Lookup SHALL be combinational with 0-cycle latency: hit = valid & tag match; pred_taken = hit & cnt[CNT_W-1]; pred_target = pred_taken ? entry target : if_pc+4 (modulo 2^32).
REQ-023 On an ex_valid hit, the entry SHALL update at the next edge: cnt increments if ex_taken, saturating at 2^CNT_W-1; cnt decrements if not taken, saturating at 0; target is overwritten with ex_target only when taken.
REQ-024 On an ex_valid miss with ex_taken=1, the entry SHALL be allocated or replaced: valid=1, new tag, target=ex_target, cnt=2^(CNT_W-1) (weakly taken).
REQ-025 An ex_valid miss with ex_taken=0 SHALL leave the table unchanged.
REQ-026 A lookup and an update to the same index in the same cycle SHALL make the lookup return the pre-update contents (no bypass); the update SHALL become visible the following cycle.
REQ-027 mispredict SHALL be combinational and equal ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_target != ex_pred_target)).
REQ-028 redirect_pc SHALL be ex_taken ? ex_target : ex_pc+4.
REQ-029 With MODE=0: pred_taken SHALL be 0, pred_target SHALL be if_pc+4, and the table SHALL never be written; mispredict and statistics SHALL behave as in MODE=1.
REQ-030 stat_branches SHALL increment on ex_valid and stat_mispredicts SHALL increment on mispredict, both saturating at 32'hFFFFFFFF.
REQ-031 When stat_clr and an increment occur in the same cycle, clear SHALL win and the result SHALL be 0.
REQ-032 The block SHALL hold no stall input; the top SHALL keep if_pc stable during a PC hold, and the lookup then repeats harmlessly.

Reset
REQ-033 While rst_n=0 at an edge: all valid bits, stat_branches and stat_mispredicts SHALL be cleared to 0, and any concurrent update SHALL be ignored.
REQ-034 After reset, pred_taken SHALL be 0 and pred_target SHALL be if_pc+4 for every if_pc; mispredict SHALL follow only its inputs.
REQ-035 Target and cnt storage need not be reset.

Structure
REQ-036 A shared package SHALL hold the MODE encodings (BP_MODE_STATIC=0, BP_MODE_BIMODAL=1) and the weakly-taken initial-count expression.
REQ-037 One sub-module, bp_sat_cnt (a CNT_W-bit saturating up/down next-value function), SHALL be instantiated once per write port.

Verification
REQ-038 Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104, both stats 0.
REQ-039 ex_valid, ex_pc=0x100, taken to 0x80, pred 0 -> mispredict=1, redirect=0x80; next cycle if_pc=0x100 -> pred_taken=1, target=0x80.
REQ-040 Same branch resolved taken three more times, then not-taken twice (CNT_W=2) -> cnt 3 then 1, and lookup then gives pred_taken=0, target 0x104.
REQ-041 ENTRIES=16 aliasing: allocate 0x100, then taken 0x140 (same index, different tag) -> 0x100 misses, 0x140 hits.
REQ-042 Preload stat_mispredicts at 0xFFFFFFFF, force a mispredict -> value holds; assert stat_clr with a mispredict in the same cycle -> value 0.
REQ-043 MODE=0 with taken branches repeated -> pred_taken stays 0 and every taken resolution asserts mispredict.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor.
// Mode encodings and the weakly-taken counter seed.
package branch_predictor_pkg;

  localparam int BP_MODE_STATIC  = 0;
  localparam int BP_MODE_BIMODAL = 1;

  function automatic int unsigned bp_weak_init(input int unsigned cnt_w);
    return 32'd1 << (cnt_w - 1);
  endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// Saturating up/down next-value function.
// Pure combinational; the caller owns the storage.
module bp_sat_cnt #(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt,
  input  logic         up,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = cnt;
    if (up) begin
      if (cnt != '1)
        nxt = cnt + 1'b1;
    end else begin
      if (cnt != '0)
        nxt = cnt - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal BTB branch predictor with EX-side resolution
// and saturating branch/mispredict statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int MODE    = BP_MODE_BIMODAL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  input  logic        stat_clr,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam bit BIMODAL = (MODE == BP_MODE_BIMODAL);
  localparam logic [CNT_W-1:0] CNT_WEAK =
    CNT_W'(bp_weak_init(CNT_W));

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [31:0]        targets [ENTRIES];
  logic [CNT_W-1:0]   cnts    [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic [CNT_W-1:0] cnt_nxt;
  logic [31:0]      stat_br_q;
  logic [31:0]      stat_mis_q;
  logic             unused_ok;

  assign unused_ok = ^{if_pc, ex_pc};

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign if_hit = valid[if_idx] && (tags[if_idx] == if_tag);

  assign pred_taken  = BIMODAL && if_hit && cnts[if_idx][CNT_W-1];
  assign pred_target = pred_taken ? targets[if_idx] : if_pc + 32'd4;

  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_hit = valid[ex_idx] && (tags[ex_idx] == ex_tag);

  bp_sat_cnt #(.W(CNT_W)) u_sat_cnt (
    .cnt (cnts[ex_idx]),
    .up  (ex_taken),
    .nxt (cnt_nxt)
  );

  // Only valid bits are reset; stale targets/counts are masked by valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (BIMODAL && ex_valid) begin
      if (ex_hit) begin
        cnts[ex_idx] <= cnt_nxt;
        if (ex_taken)
          targets[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        valid[ex_idx]   <= 1'b1;
        tags[ex_idx]    <= ex_tag;
        targets[ex_idx] <= ex_target;
        cnts[ex_idx]    <= CNT_WEAK;
      end
    end
  end

  assign mispredict = ex_valid &&
    ((ex_taken != ex_pred_taken) ||
     (ex_taken && (ex_target != ex_pred_target)));

  assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (ex_valid && stat_br_q != '1)
        stat_br_q <= stat_br_q + 32'd1;
      if (mispredict && stat_mis_q != '1)
        stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: bimodal and static predictors vs.
// a table-based reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        stat_clr;

  logic        pt_b, pt_s, mp_b, mp_s;
  logic [31:0] ptg_b, ptg_s, rd_b, rd_s;
  logic [31:0] sb_b, sb_s, sm_b, sm_s;

  always #5 clk = ~clk;

  branch_predictor #(.MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pt_b), .pred_target(ptg_b),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .mispredict(mp_b), .redirect_pc(rd_b), .stat_clr(stat_clr),
    .stat_branches(sb_b), .stat_mispredicts(sm_b)
  );

  branch_predictor #(.MODE(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pt_s), .pred_target(ptg_s),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .mispredict(mp_s), .redirect_pc(rd_s), .stat_clr(stat_clr),
    .stat_branches(sb_s), .stat_mispredicts(sm_s)
  );

  typedef struct {
    logic [31:0] ipc;
    logic        pt;
    logic [31:0] ptg;
    logic        mp;
    logic [31:0] rd;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: 16 entries, 8-bit tags, 2-bit counters.
  bit          m_v   [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_cnt [16];
  logic [31:0] m_sb, m_sm;

  function automatic void model_pred(input logic [31:0] pc,
                                     output logic t,
                                     output logic [31:0] tg);
    int idx = int'((pc >> 2) % 16);
    int unsigned tag = (pc >> 6) % 256;
    t  = m_v[idx] && m_tag[idx] == tag && m_cnt[idx] >= 2;
    tg = t ? m_tgt[idx] : pc + 32'd4;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic step(input logic r, input logic [31:0] ipc,
                      input logic ev, input logic [31:0] epc,
                      input logic tk, input logic [31:0] tgt,
                      input logic use_model, input logic ept,
                      input logic [31:0] eptg, input logic clr);
    exp_t e;
    logic pt;
    logic [31:0] ptg;
    int idx;
    int unsigned tag;
    bit hit;
    logic mp;
    if (use_model) model_pred(epc, ept, eptg);
    rst_n = r; if_pc = ipc; ex_valid = ev; ex_pc = epc;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = ept;
    ex_pred_target = eptg; stat_clr = clr;
    model_pred(ipc, pt, ptg);
    mp = ev && (tk != ept || (tk && tgt != eptg));
    e.ipc = ipc; e.pt = pt; e.ptg = ptg; e.mp = mp;
    e.rd = tk ? tgt : epc + 32'd4;
    e.sb = m_sb; e.sm = m_sm;
    q.push_back(e);
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 16; i++) m_v[i] = 0;
      m_sb = 0; m_sm = 0;
    end else begin
      if (clr) begin
        m_sb = 0; m_sm = 0;
      end else begin
        if (ev && m_sb != 32'hFFFFFFFF) m_sb++;
        if (mp && m_sm != 32'hFFFFFFFF) m_sm++;
      end
      if (ev) begin
        idx = int'((epc >> 2) % 16);
        tag = (epc >> 6) % 256;
        hit = m_v[idx] && m_tag[idx] == tag;
        if (hit) begin
          m_cnt[idx] = tk ? (m_cnt[idx] == 3 ? 3 : m_cnt[idx] + 1)
                          : (m_cnt[idx] == 0 ? 0 : m_cnt[idx] - 1);
          if (tk) m_tgt[idx] = tgt;
        end else if (tk) begin
          m_v[idx] = 1; m_tag[idx] = tag;
          m_tgt[idx] = tgt; m_cnt[idx] = 2;
        end
      end
    end
    #1;
  endtask

  task automatic lookup(input logic [31:0] ipc);
    step(1, ipc, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
  endtask

  task automatic resolve(input logic [31:0] ipc, input logic [31:0] epc,
                         input logic tk, input logic [31:0] tgt);
    step(1, ipc, 1, epc, tk, tgt, 1, 0, 32'h0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pred_taken", {31'd0, pt_b}, {31'd0, e.pt});
        chk("pred_target", ptg_b, e.ptg);
        chk("mispredict", {31'd0, mp_b}, {31'd0, e.mp});
        chk("redirect_pc", rd_b, e.rd);
        chk("stat_branches", sb_b, e.sb);
        chk("stat_mispredicts", sm_b, e.sm);
        chk("static_pred_taken", {31'd0, pt_s}, 32'd0);
        chk("static_pred_target", ptg_s, e.ipc + 32'd4);
        chk("static_mispredict", {31'd0, mp_s}, {31'd0, e.mp});
        chk("static_stat_branches", sb_s, e.sb);
      end
    end
  end

  localparam int NPC = 6;
  logic [31:0] pcs [NPC] = '{32'h100, 32'h140, 32'h104,
                             32'h180, 32'h1100, 32'h3c};

  initial begin : driver
    int wait_cnt;
    logic [31:0] p, t;
    m_sb = 0; m_sm = 0;
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_cnt[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
    end
    rst_n = 0; if_pc = 32'h100; ex_valid = 1; ex_pc = 32'h100;
    ex_taken = 1; ex_target = 32'h80; ex_pred_taken = 0;
    ex_pred_target = 32'h104; stat_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    lookup(32'h100);
    resolve(32'h100, 32'h100, 1, 32'h80);
    lookup(32'h100);
    repeat (3) resolve(32'h100, 32'h100, 1, 32'h80);
    repeat (2) resolve(32'h100, 32'h100, 0, 32'h80);
    lookup(32'h100);
    resolve(32'h100, 32'h100, 1, 32'h80);
    resolve(32'h140, 32'h140, 1, 32'h200);
    lookup(32'h100);
    lookup(32'h140);
    resolve(32'h140, 32'h140, 1, 32'h240);
    lookup(32'h140);
    dut.stat_mis_q = 32'hFFFFFFFF;
    m_sm = 32'hFFFFFFFF;
    step(1, 32'h100, 1, 32'h100, 1, 32'h80, 0, 0, 32'h0, 0);
    lookup(32'h100);
    step(1, 32'h100, 1, 32'h100, 1, 32'h80, 0, 0, 32'h0, 1);
    lookup(32'h100);
    step(0, 32'h140, 1, 32'h140, 1, 32'h300, 1, 0, 32'h0, 0);
    lookup(32'h140);
    repeat (400) begin
      p = pcs[$urandom_range(NPC - 1)];
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0) t = 32'h80;
      if ($urandom_range(3) == 0)
        step(1, pcs[$urandom_range(NPC - 1)], 1'($urandom_range(1)),
             p, 1'($urandom_range(1)), t, 0, 1'($urandom_range(1)),
             32'h80, ($urandom_range(15) == 0));
      else
        step(1, pcs[$urandom_range(NPC - 1)], 1'($urandom_range(1)),
             p, 1'($urandom_range(1)), t, 1, 0, 32'h0,
             ($urandom_range(15) == 0));
    end
    ex_valid = 0;
    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
